sda_to_par: RTL and testbench
=============================

SDA_TO_PAR -- requirements
Module: sda_to_par

Interface
REQ-001 Parameter: DW, 4, number of data bits per frame (MSB first).
REQ-002 Port: sclk  input  1  receiver system clock; all state changes on its rising edge; frequency SHALL be at least 8x the scl frequency.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: scl  input  1  serial clock from the transmitter, asynchronous to sclk.
REQ-005 Port: sda  input  1  serial data from the transmitter, asynchronous to sclk.
REQ-006 Port: data_out  output  DW  last correctly received frame, held until the next valid frame.
REQ-007 Port: valid  output  1  one-sclk pulse when data_out is updated.
REQ-008 Port: err  output  1  one-sclk pulse when a frame is aborted by a stop that arrives too early.
REQ-009 Port: outhigh  output  2**DW  one-hot decode of data_out; bit data_out is high.
REQ-010 Port: frame_cnt  output  8  count of valid frames, wraps 255->0.

Function
REQ-011 scl and sda SHALL each pass through a 2-flop synchronizer; the second-stage values (scl_s, sda_s) and their one-cycle-delayed copies are the only signals used for detection.
REQ-012 Start SHALL be detected when sda_s falls while scl_s is high; stop when sda_s rises while scl_s is high; a bit edge when scl_s rises.
REQ-013 States: IDLE, RECV, WAIT_STOP; reset state IDLE.
REQ-014 IDLE: start -> RECV, bit counter cleared, shift register cleared; scl edges and stop ignored.
REQ-015 RECV: on each scl_s rising edge, shift sda_s in at the LSB (MSB first overall) and increment the counter; when the counter reaches DW -> WAIT_STOP.
REQ-016 WAIT_STOP: further scl_s rising edges SHALL be ignored (the transmitter's stop-setup bit with sda=0 is discarded); stop -> IDLE with frame accepted.
REQ-017 Frame accepted: data_out <= shift register, outhigh <= one-hot of that value, valid = 1 for exactly one cycle, frame_cnt increments by 1 modulo 256.
REQ-018 Stop while in RECV (fewer than DW bits): err = 1 for one cycle, state -> IDLE; data_out, outhigh and frame_cnt unchanged.
REQ-019 Start while in RECV or WAIT_STOP (repeated start): discard partial data, clear counter and shift register, remain or enter RECV; no valid, no err.
REQ-020 Latency: valid, err and the data_out update SHALL occur at the 3rd sclk rising edge after the sda pin transition that forms the stop (2 sync stages plus 1 registered output stage).
REQ-021 valid and err SHALL never be high in the same cycle; both are 0 outside their pulse cycle.
REQ-022 Simultaneous scl_s rise and sda_s change in the same cycle SHALL be treated as a bit edge only (no start/stop).

Reset
REQ-023 While rst is high: state IDLE, data_out = 0, valid = 0, err = 0, outhigh = 0 (all bits low), frame_cnt = 0, synchronizer flops = 1, counter and shift register = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately with no valid/err pulse; after release, reception restarts only on a new start condition.

Verification
REQ-025 Frame 4'b1011 (start, 4 bits, stop-setup 0 bit, stop) -> exactly one valid pulse 3 sclk after sda rise, data_out = 4'hB, outhigh = 16'h0800, frame_cnt = 1.
REQ-026 Stop after 2 bits (1,0) -> one err pulse, no valid, data_out/outhigh/frame_cnt keep previous values.
REQ-027 Start, bits 1,1, repeated start, then full frame 4'b0010 and stop -> single valid, data_out = 4'h2, outhigh = 16'h0004, no err.
REQ-028 256 back-to-back valid frames of 4'h0 -> 256 valid pulses, frame_cnt returns to 0, outhigh = 16'h0001.
REQ-029 rst asserted after 3 bits of a frame, released, then a new frame 4'hF -> no pulse during the aborted frame, then data_out = 4'hF, outhigh = 16'h8000, frame_cnt = 1.
REQ-030 scl toggling with sda constant high before any start -> no valid, no err, all outputs remain at reset values.

Source files
------------

// File: rtl/sda_to_par.sv
// Serial-to-parallel receiver for a start/stop framed two-wire link.
// The scl/sda pins are oversampled on sclk and each frame is delivered as a word plus its one-hot decode.
module sda_to_par #(
  parameter int unsigned DW = 4
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                scl,
  input  logic                sda,
  output logic [DW-1:0]       data_out,
  output logic                valid,
  output logic                err,
  output logic [(2**DW)-1:0]  outhigh,
  output logic [7:0]          frame_cnt
);

  localparam int unsigned CW = $clog2(DW + 1);
  localparam int unsigned OW = 2 ** DW;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWaitStop
  } state_e;

  // Two-stage synchronizers plus one delayed copy for edge detection.
  // All of these reset high so that idle pins do not look like edges.
  logic scl_m, scl_s, scl_d;
  logic sda_m, sda_s, sda_d;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_d <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= sda;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  logic scl_rise;
  logic start_det;
  logic stop_det;

  // A data change coinciding with an scl rise counts only as a bit edge.
  assign scl_rise  = scl_s & ~scl_d;
  assign start_det = scl_s & ~scl_rise & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~scl_rise & ~sda_d & sda_s;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          accept;
  logic          abort;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    accept  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_det) begin
          state_d = StRecv;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StRecv: begin
        if (start_det) begin
          cnt_d   = '0;
          shift_d = '0;
        end else if (stop_det) begin
          abort   = 1'b1;
          state_d = StIdle;
        end else if (scl_rise) begin
          shift_d = DW'({shift_q, sda_s});
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            state_d = StWaitStop;
          end
        end
      end
      StWaitStop: begin
        // The stop-setup clock (sda low) lands here and is ignored.
        if (start_det) begin
          state_d = StRecv;
          cnt_d   = '0;
          shift_d = '0;
        end else if (stop_det) begin
          accept  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      outhigh   <= '0;
      frame_cnt <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= accept;
      err   <= abort;
      if (accept) begin
        data_out  <= shift_q;
        outhigh   <= OW'(1) << shift_q;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sda_to_par.sv
// Directed bench for sda_to_par: pin-level frames with hand-computed results.
module tb_sda_to_par;

  localparam int unsigned DW = 4;

  logic                sclk;
  logic                rst;
  logic                scl;
  logic                sda;
  logic [DW-1:0]       data_out;
  logic                valid;
  logic                err;
  logic [(2**DW)-1:0]  outhigh;
  logic [7:0]          frame_cnt;

  int nvec;
  int nfail;
  int nvalid;
  int nerr;
  logic overlap;

  sda_to_par #(.DW(DW)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .data_out  (data_out),
    .valid     (valid),
    .err       (err),
    .outhigh   (outhigh),
    .frame_cnt (frame_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(posedge sclk) begin
    if (valid) nvalid <= nvalid + 1;
    if (err) nerr <= nerr + 1;
    if (valid && err) overlap <= 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic i2c_start();
    sda = 1'b1;
    tick(4);
    scl = 1'b1;
    tick(8);
    sda = 1'b0;
    tick(8);
    scl = 1'b0;
    tick(4);
  endtask

  task automatic send_bit(input logic b);
    sda = b;
    tick(4);
    scl = 1'b1;
    tick(8);
    scl = 1'b0;
    tick(4);
  endtask

  // Stop-setup clock with sda low, then sda rises; watch 12 edges for pulses.
  task automatic stop_watch(output int vc, output int ec, output int lat);
    sda = 1'b0;
    tick(4);
    scl = 1'b1;
    tick(8);
    sda = 1'b1;
    vc = 0;
    ec = 0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge sclk);
      #1;
      if (valid) begin
        vc++;
        if (lat == 0) lat = i;
      end
      if (err) begin
        ec++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] v, output int vc, output int ec,
                            output int lat);
    i2c_start();
    for (int i = DW - 1; i >= 0; i--) send_bit(v[i]);
    stop_watch(vc, ec, lat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scl = 1'b1;
    sda = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scl = 1'b1;
    sda = 1'b1;
    tick(3);
    @(negedge sclk);
    nvec++;
    if (data_out !== 4'h0) begin
      nfail++;
      $display("FAIL reset_data_out got %h want 0", data_out);
    end
    nvec++;
    if (outhigh !== 16'h0000) begin
      nfail++;
      $display("FAIL reset_outhigh got %h want 0000", outhigh);
    end
    nvec++;
    if (frame_cnt !== 8'd0) begin
      nfail++;
      $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
    end
    nvec++;
    if (valid !== 1'b0 || err !== 1'b0) begin
      nfail++;
      $display("FAIL reset_pulses got valid=%b err=%b want 0 0", valid, err);
    end
    #1;
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_idle_scl();
    int v0, e0;
    v0 = nvalid;
    e0 = nerr;
    sda = 1'b1;
    for (int i = 0; i < 6; i++) begin
      scl = 1'b0;
      tick(8);
      scl = 1'b1;
      tick(8);
    end
    tick(4);
    @(negedge sclk);
    nvec++;
    if (nvalid != v0 || nerr != e0) begin
      nfail++;
      $display("FAIL idle_scl_pulses got valid=%0d err=%0d want 0 0", nvalid - v0, nerr - e0);
    end
    nvec++;
    if (data_out !== 4'h0 || outhigh !== 16'h0000 || frame_cnt !== 8'd0) begin
      nfail++;
      $display("FAIL idle_scl_outputs got %h %h %0d want 0 0000 0", data_out, outhigh,
               frame_cnt);
    end
    #1;
  endtask

  task automatic test_frame_b();
    int vc, ec, lat;
    send_frame(4'b1011, vc, ec, lat);
    nvec++;
    if (vc != 1 || ec != 0) begin
      nfail++;
      $display("FAIL frame_b_pulses got valid=%0d err=%0d want 1 0", vc, ec);
    end
    nvec++;
    if (lat != 3) begin
      nfail++;
      $display("FAIL frame_b_latency got %0d want 3", lat);
    end
    nvec++;
    if (data_out !== 4'hB) begin
      nfail++;
      $display("FAIL frame_b_data got %h want b", data_out);
    end
    nvec++;
    if (outhigh !== 16'h0800) begin
      nfail++;
      $display("FAIL frame_b_outhigh got %h want 0800", outhigh);
    end
    nvec++;
    if (frame_cnt !== 8'd1) begin
      nfail++;
      $display("FAIL frame_b_cnt got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_early_stop();
    int vc, ec, lat;
    i2c_start();
    send_bit(1'b1);
    send_bit(1'b0);
    stop_watch(vc, ec, lat);
    nvec++;
    if (vc != 0 || ec != 1) begin
      nfail++;
      $display("FAIL early_stop_pulses got valid=%0d err=%0d want 0 1", vc, ec);
    end
    nvec++;
    if (lat != 3) begin
      nfail++;
      $display("FAIL early_stop_latency got %0d want 3", lat);
    end
    nvec++;
    if (data_out !== 4'hB || outhigh !== 16'h0800 || frame_cnt !== 8'd1) begin
      nfail++;
      $display("FAIL early_stop_hold got %h %h %0d want b 0800 1", data_out, outhigh,
               frame_cnt);
    end
  endtask

  task automatic test_repeated_start();
    int vc, ec, lat, v0, e0;
    v0 = nvalid;
    e0 = nerr;
    i2c_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(4'b0010, vc, ec, lat);
    nvec++;
    if (nvalid - v0 != 1 || nerr != e0) begin
      nfail++;
      $display("FAIL rep_start_pulses got valid=%0d err=%0d want 1 0", nvalid - v0, nerr - e0);
    end
    nvec++;
    if (data_out !== 4'h2) begin
      nfail++;
      $display("FAIL rep_start_data got %h want 2", data_out);
    end
    nvec++;
    if (outhigh !== 16'h0004) begin
      nfail++;
      $display("FAIL rep_start_outhigh got %h want 0004", outhigh);
    end
    nvec++;
    if (frame_cnt !== 8'd2) begin
      nfail++;
      $display("FAIL rep_start_cnt got %0d want 2", frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int vc, ec, lat, v0, e0;
    do_reset();
    v0 = nvalid;
    e0 = nerr;
    for (int i = 0; i < 255; i++) send_frame(4'h0, vc, ec, lat);
    nvec++;
    if (frame_cnt !== 8'd255) begin
      nfail++;
      $display("FAIL b2b_cnt_255 got %0d want 255", frame_cnt);
    end
    send_frame(4'h0, vc, ec, lat);
    nvec++;
    if (nvalid - v0 != 256 || nerr != e0) begin
      nfail++;
      $display("FAIL b2b_pulses got valid=%0d err=%0d want 256 0", nvalid - v0, nerr - e0);
    end
    nvec++;
    if (frame_cnt !== 8'd0) begin
      nfail++;
      $display("FAIL b2b_cnt_wrap got %0d want 0", frame_cnt);
    end
    nvec++;
    if (outhigh !== 16'h0001 || data_out !== 4'h0) begin
      nfail++;
      $display("FAIL b2b_outhigh got %h data %h want 0001 0", outhigh, data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    int vc, ec, lat, v0, e0;
    v0 = nvalid;
    e0 = nerr;
    i2c_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    scl = 1'b1;
    sda = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(20);
    nvec++;
    if (nvalid != v0 || nerr != e0) begin
      nfail++;
      $display("FAIL rst_mid_pulses got valid=%0d err=%0d want 0 0", nvalid - v0, nerr - e0);
    end
    nvec++;
    if (frame_cnt !== 8'd0 || data_out !== 4'h0) begin
      nfail++;
      $display("FAIL rst_mid_cleared got cnt=%0d data=%h want 0 0", frame_cnt, data_out);
    end
    send_frame(4'hF, vc, ec, lat);
    nvec++;
    if (vc != 1 || ec != 0) begin
      nfail++;
      $display("FAIL rst_mid_frame_pulses got valid=%0d err=%0d want 1 0", vc, ec);
    end
    nvec++;
    if (data_out !== 4'hF || outhigh !== 16'h8000 || frame_cnt !== 8'd1) begin
      nfail++;
      $display("FAIL rst_mid_frame_out got %h %h %0d want f 8000 1", data_out, outhigh,
               frame_cnt);
    end
  endtask

  initial begin
    nvec = 0;
    nfail = 0;
    nvalid = 0;
    nerr = 0;
    overlap = 1'b0;
    rst = 1'b1;
    scl = 1'b1;
    sda = 1'b1;
    test_reset();
    test_idle_scl();
    test_frame_b();
    test_early_stop();
    test_repeated_start();
    test_back_to_back();
    test_reset_mid_frame();
    nvec++;
    if (overlap !== 1'b0) begin
      nfail++;
      $display("FAIL valid_err_overlap got %b want 0", overlap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
